// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle word RAM behind ready/valid request and response channels.
// Define DATA_MEM_ALIGN_CHECK_EN to reject misaligned byte addresses with an error response.
module data_mem_responder #(
    parameter int ADDR_W      = 5,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_address_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic write_q, write_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0] mem [2**ADDR_W];
    logic accept, commit, c_write, c_err;
    logic [31:0] c_addr, c_wdata;
    logic [ADDR_W-1:0] c_idx;

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_error_o = err_q;

    // With zero wait states the commit uses the live request on its acceptance edge.
    always_comb begin
        accept  = (state_q == S_IDLE) && req_valid_i;
        c_write = accept ? req_write_i : write_q;
        c_addr  = accept ? req_address_i : addr_q;
        c_wdata = accept ? req_wdata_i : wdata_q;
        c_idx   = c_addr[ADDR_W+1:2];
        commit  = (accept && WAIT_STATES == 0) || (state_q == S_WAIT && cnt_q == 4'd1);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        c_err   = (c_addr[31:ADDR_W+2] != '0) || (c_addr[1:0] != 2'b00);
`else
        c_err   = (c_addr[31:ADDR_W+2] != '0);
`endif
    end

`ifndef DATA_MEM_ALIGN_CHECK_EN
    logic unused_lsb;
    assign unused_lsb = ^c_addr[1:0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            write_d = req_write_i;
            addr_d  = req_address_i;
            wdata_d = req_wdata_i;
            cnt_d   = 4'(WAIT_STATES);
            state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
        if (state_q == S_WAIT) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? S_RESP : S_WAIT;
        end
        if (state_q == S_RESP && resp_ready_i)
            state_d = S_IDLE;
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_err || c_write) ? 32'd0 : mem[c_idx];
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock_i) begin
        if (reset_i && commit && c_write && !c_err)
            mem[c_idx] <= c_wdata;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench driving a 2-wait-state and a 0-wait-state responder.
// Expected responses follow DATA_MEM_ALIGN_CHECK_EN when it is defined.
module tb_data_mem_responder;
    logic clock = 1'b0;
    logic reset_n;
    logic rv[2], rw[2], rr[2], rq_rdy[2], rs_v[2], rs_err[2];
    logic [31:0] ra[2], wd[2], rs_d[2];
    logic [31:0] model[2][32];
    int checks = 0;
    int failures = 0;

    typedef struct {logic [31:0] d; logic e;} exp_t;
    exp_t sbq[$];

    always #5 clock = ~clock;

    data_mem_responder #(.ADDR_W(5), .WAIT_STATES(2)) u0 (
        .clock_i(clock), .reset_i(reset_n),
        .req_valid_i(rv[0]), .req_ready_o(rq_rdy[0]), .req_write_i(rw[0]),
        .req_address_i(ra[0]), .req_wdata_i(wd[0]),
        .resp_valid_o(rs_v[0]), .resp_ready_i(rr[0]),
        .resp_rdata_o(rs_d[0]), .resp_error_o(rs_err[0])
    );

    data_mem_responder #(.ADDR_W(5), .WAIT_STATES(0)) u1 (
        .clock_i(clock), .reset_i(reset_n),
        .req_valid_i(rv[1]), .req_ready_o(rq_rdy[1]), .req_write_i(rw[1]),
        .req_address_i(ra[1]), .req_wdata_i(wd[1]),
        .resp_valid_o(rs_v[1]), .resp_ready_i(rr[1]),
        .resp_rdata_o(rs_d[1]), .resp_error_o(rs_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wdv, input int hold);
        exp_t e, p;
        logic err;
        int n;
        err = (a[31:7] != 25'd0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        err = err || (a[1:0] != 2'b00);
`endif
        e.e = err;
        e.d = (err || w) ? 32'd0 : model[d][a[6:2]];
        if (!err && w) model[d][a[6:2]] = wdv;
        sbq.push_back(e);
        check("req_ready_idle", rq_rdy[d], 1);
        rv[d] = 1'b1; rw[d] = w; ra[d] = a; wd[d] = wdv;
        n = 0;
        do begin
            @(posedge clock); #1;
            rv[d] = 1'b0;
            n++;
        end while (!rs_v[d] && n < 40);
        check("latency", n, (d == 0) ? 3 : 1);
        p = sbq.pop_front();
        // Competing stores target words 8.. while the response is stalled.
        for (int i = 0; i < hold; i++) begin
            rv[d] = 1'b1; rw[d] = 1'b1; ra[d] = 32'h20 + 32'(i * 4); wd[d] = 32'hFFFF0000 | 32'(i);
            @(posedge clock); #1;
            check("hold_valid", rs_v[d], 1);
            check("hold_rdata", rs_d[d], p.d);
            check("hold_error", rs_err[d], p.e);
            check("hold_req_ready", rq_rdy[d], 0);
        end
        rv[d] = 1'b0;
        check("resp_rdata", rs_d[d], p.d);
        check("resp_error", rs_err[d], p.e);
        rr[d] = 1'b1;
        @(posedge clock); #1;
        rr[d] = 1'b0;
        check("resp_done_valid", rs_v[d], 0);
        check("resp_done_ready", rq_rdy[d], 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; rr[i] = 1'b0; ra[i] = 32'd0; wd[i] = 32'd0;
        end
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid0", rs_v[0], 0);
        check("rst_ready0", rq_rdy[0], 1);
        check("rst_valid1", rs_v[1], 0);
        check("rst_ready1", rq_rdy[1], 1);
        check("rst_rdata0", rs_d[0], 0);
        check("rst_error0", rs_err[0], 0);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);
        txn(1, 1'b1, 32'h04, 32'h12345678, 0);
        txn(1, 1'b0, 32'h04, 32'h0, 0);
        txn(0, 1'b1, 32'h00, 32'h0BADF00D, 0);
        txn(0, 1'b0, 32'h80, 32'h0, 0);
        txn(0, 1'b0, 32'h00, 32'h0, 0);
        txn(1, 1'b1, 32'h100, 32'h99999999, 0);
        txn(1, 1'b0, 32'h80, 32'h0, 0);
        txn(0, 1'b1, 32'h20, 32'h5A5A5A5A, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 10);
        txn(0, 1'b0, 32'h20, 32'h0, 0);
        txn(0, 1'b0, 32'h24, 32'h0, 0);

        // Store aborted by reset while waiting must never reach storage.
        txn(0, 1'b1, 32'h0C, 32'h11112222, 0);
        txn(0, 1'b1, 32'h24, 32'h31313131, 0);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h0C; wd[0] = 32'hAAAA5555;
        @(posedge clock); #1;
        rv[0] = 1'b0;
        check("abort_in_wait", rq_rdy[0], 0);
        reset_n = 1'b0;
        #1;
        check("abort_rst_valid", rs_v[0], 0);
        check("abort_rst_ready", rq_rdy[0], 1);
        @(posedge clock); @(posedge clock); @(posedge clock); #1;
        check("abort_rst_hold_valid", rs_v[0], 0);
        reset_n = 1'b1;
        txn(0, 1'b0, 32'h0C, 32'h0, 0);
        txn(0, 1'b0, 32'h24, 32'h0, 0);

        txn(0, 1'b1, 32'h04, 32'h77778888, 0);
        txn(0, 1'b1, 32'h06, 32'hCAFE0000, 0);
        txn(0, 1'b0, 32'h04, 32'h0, 0);
        txn(1, 1'b1, 32'h86, 32'h13579BDF, 0);
        txn(1, 1'b0, 32'h04, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
